rs232_frame_ctrl: RTL and testbench

//   Command-frame sequencer between the UART byte receiver and the UART byte transmitter.
//   - Parses 8-byte host frames: STX, CMD, D0..D3, PAD(00), ETX.
//   - Writes a 32-bit data or key word and pulses load strobes to the port-B and AES paths.
//   - For read commands, transmits the stored word back as an 8-byte reply, one TX byte at a time.

---
 rtl/rs232_frame_ctrl_if.sv | 25 ++
 rtl/rs232_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rs232_frame_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_frame_ctrl_if.sv
// UART byte-level handshake between the frame sequencer and the
// receiver/transmitter pair.
interface rs232_frame_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_byte;

  modport master (
    input  rx_valid,
    input  rx_byte,
    input  tx_busy,
    output tx_start,
    output tx_byte
  );

  modport slave (
    output rx_valid,
    output rx_byte,
    output tx_busy,
    input  tx_start,
    input  tx_byte
  );
endinterface

// File: rtl/rs232_frame_ctrl.sv
// Command-frame sequencer: parses 8-byte host frames (STX CMD D0..D3 00 ETX),
// updates the data/key words with load strobes, and replies to read commands
// with an 8-byte frame sent one byte at a time.
module rs232_frame_ctrl #(
  parameter logic [7:0]  STX         = 8'h02,
  parameter logic [7:0]  ETX         = 8'h03,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  rs232_frame_ctrl_if.master    uart,
  output logic [31:0]           word_out,
  output logic [31:0]           key_out,
  output logic                  word_load,
  output logic                  key_load,
  output logic                  load_port_b,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    frame [1:7];
  logic [2:0]    rx_idx;
  logic [2:0]    tx_idx;
  logic [63:0]   reply;
  logic          seen_busy;

  logic [7:0]    cmd;
  logic [31:0]   data;
  logic          cmd_legal, frame_ok, is_read;
  logic          timeout_hit;
  logic          wr_word, wr_key, err_nx;

  assign cmd       = frame[1];
  assign data      = {frame[5], frame[4], frame[3], frame[2]};
  assign cmd_legal = (cmd == 8'hFF) || (cmd == 8'hFE) || (cmd == 8'h7F) || (cmd == 8'h7E);
  assign frame_ok  = cmd_legal && (frame[6] == 8'h00) && (frame[7] == ETX);
  assign is_read   = (cmd == 8'h7F) || (cmd == 8'h7E);
  assign busy      = (state != S_IDLE);

  // Timeout fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
  assign timeout_hit = (state == S_RECV) && !uart.rx_valid &&
                       (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Next-state and strobe decode.
  always_comb begin
    state_nx = state;
    wr_word  = 1'b0;
    wr_key   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (uart.rx_valid && uart.rx_byte == STX) state_nx = S_RECV;
      end
      S_RECV: begin
        if (uart.rx_valid && rx_idx == 3'd7) begin
          state_nx = S_CHECK;
        end else if (timeout_hit) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_CHECK: begin
        state_nx = S_IDLE;
        if (!frame_ok) begin
          err_nx = 1'b1;
        end else if (is_read) begin
          state_nx = S_TX_SEND;
        end else if (cmd == 8'hFF) begin
          wr_word = 1'b1;
        end else begin
          wr_key = 1'b1;
        end
      end
      S_TX_SEND: begin
        if (!uart.tx_busy) state_nx = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (seen_busy && !uart.tx_busy) state_nx = (tx_idx == 3'd7) ? S_IDLE : S_TX_SEND;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, datapath registers and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tmo_cnt       <= '0;
      rx_idx        <= '0;
      tx_idx        <= '0;
      reply         <= '0;
      seen_busy     <= 1'b0;
      word_out      <= '0;
      key_out       <= '0;
      word_load     <= 1'b0;
      key_load      <= 1'b0;
      load_port_b   <= 1'b0;
      frame_err     <= 1'b0;
      uart.tx_start <= 1'b0;
      uart.tx_byte  <= '0;
      for (int unsigned i = 1; i <= 7; i++) frame[i] <= '0;
    end else begin
      state         <= state_nx;
      word_load     <= wr_word;
      key_load      <= wr_key;
      load_port_b   <= wr_word | wr_key;
      frame_err     <= err_nx;
      uart.tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (uart.rx_valid && uart.rx_byte == STX) begin
            rx_idx  <= 3'd1;
            tmo_cnt <= '0;
          end
        end
        S_RECV: begin
          if (uart.rx_valid) begin
            frame[rx_idx] <= uart.rx_byte;
            rx_idx        <= rx_idx + 3'd1;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (wr_word) word_out <= data;
          if (wr_key)  key_out  <= data;
          // Reply is snapshotted here so later writes cannot alter it.
          if (frame_ok && is_read) begin
            reply  <= {ETX, 8'h00, (cmd == 8'h7F) ? word_out : key_out, cmd, STX};
            tx_idx <= '0;
          end
        end
        S_TX_SEND: begin
          if (!uart.tx_busy) begin
            uart.tx_start <= 1'b1;
            uart.tx_byte  <= reply[{tx_idx, 3'b000} +: 8];
            seen_busy     <= 1'b0;
          end
        end
        S_TX_WAIT: begin
          if (uart.tx_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            tx_idx <= tx_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_frame_ctrl.sv
// Bench for rs232_frame_ctrl: directed frames, a transmitter busy emulator,
// a frame-level reference model checked every cycle, and literal pins.
module tb_rs232_frame_ctrl;
  localparam int TMO      = 20;
  localparam int BUSY_LEN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs232_frame_ctrl_if u_if ();
  logic [31:0] word_out, key_out;
  logic        word_load, key_load, load_port_b, frame_err, busy;

  rs232_frame_ctrl #(.STX(8'h02), .ETX(8'h03), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart        (u_if),
    .word_out    (word_out),
    .key_out     (key_out),
    .word_load   (word_load),
    .key_load    (key_load),
    .load_port_b (load_port_b),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef enum int {M_IDLE, M_FRAME, M_BLOCK} mode_t;
  mode_t      mode;
  logic [7:0] fq[$];
  logic [7:0] txq[$];
  logic [7:0] tx_log[$];
  int         last_byte_cyc, idle_at, evt_cyc, evt_kind;
  logic [31:0] evt_val, m_word, m_key;
  bit         last_sent, last_busy_seen;
  int         n_wl, n_kl, n_fe, n_lpb;

  task automatic model_reset();
    mode = M_IDLE; fq.delete(); txq.delete();
    evt_kind = 0; idle_at = -1; m_word = '0; m_key = '0;
    last_sent = 0; last_busy_seen = 0;
  endtask

  task automatic finish_frame();
    logic [7:0]  c;
    logic [31:0] d, v;
    bit ok;
    c  = fq[0];
    d  = {fq[4], fq[3], fq[2], fq[1]};
    ok = (c == 8'hFF || c == 8'hFE || c == 8'h7F || c == 8'h7E) && fq[5] == 8'h00 && fq[6] == 8'h03;
    mode = M_BLOCK;
    if (ok && (c == 8'h7F || c == 8'h7E)) begin
      v = (c == 8'h7F) ? m_word : m_key;
      txq = '{8'h02, c, v[7:0], v[15:8], v[23:16], v[31:24], 8'h00, 8'h03};
      idle_at = -1;
    end else begin
      evt_cyc  = cyc + 2;
      evt_kind = !ok ? 3 : (c == 8'hFF ? 1 : 2);
      evt_val  = d;
      idle_at  = cyc + 1;
    end
  endtask

  // Compare process: runs once per cycle on the falling edge.
  initial begin
    logic exp_wl, exp_kl, exp_fe, exp_busy;
    model_reset();
    n_wl = 0; n_kl = 0; n_fe = 0; n_lpb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        continue;
      end
      exp_busy = (mode != M_IDLE);
      exp_wl = 0; exp_kl = 0; exp_fe = 0;
      if (evt_kind != 0 && cyc == evt_cyc) begin
        case (evt_kind)
          1: begin m_word = evt_val; exp_wl = 1; end
          2: begin m_key  = evt_val; exp_kl = 1; end
          default: exp_fe = 1;
        endcase
        evt_kind = 0;
      end
      chk("word_load", word_load, exp_wl);
      chk("key_load", key_load, exp_kl);
      chk("load_port_b", load_port_b, exp_wl | exp_kl);
      chk("frame_err", frame_err, exp_fe);
      chk("word_out", word_out, m_word);
      chk("key_out", key_out, m_key);
      chk("busy", busy, exp_busy);
      if (word_load)   n_wl++;
      if (key_load)    n_kl++;
      if (frame_err)   n_fe++;
      if (load_port_b) n_lpb++;

      if (u_if.rx_valid) begin
        case (mode)
          M_IDLE: if (u_if.rx_byte == 8'h02) begin
            fq.delete(); mode = M_FRAME; last_byte_cyc = cyc;
          end
          M_FRAME: begin
            fq.push_back(u_if.rx_byte); last_byte_cyc = cyc;
            if (fq.size() == 7) finish_frame();
          end
          default: ;
        endcase
      end

      if (u_if.tx_start) begin
        chk("tx_start_while_busy", u_if.tx_busy, 1'b0);
        tx_log.push_back(u_if.tx_byte);
        if (txq.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_start_unexpected: got tx_start=1 byte %0h expected no tx_start (cycle %0d)", u_if.tx_byte, cyc);
        end else begin
          chk("tx_byte", u_if.tx_byte, txq.pop_front());
          if (txq.size() == 0) begin last_sent = 1; last_busy_seen = 0; end
        end
      end else if (last_sent) begin
        if (u_if.tx_busy) last_busy_seen = 1;
        else if (last_busy_seen) begin last_sent = 0; mode = M_IDLE; end
      end

      if (mode == M_BLOCK && idle_at == cyc) mode = M_IDLE;
      if (mode == M_FRAME && cyc - last_byte_cyc == TMO) begin
        mode = M_IDLE; evt_cyc = cyc + 1; evt_kind = 3;
      end
    end
  end

  // Transmitter emulator: busy rises the cycle after tx_start.
  initial begin
    u_if.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.tx_start) begin
        @(posedge clk); #1 u_if.tx_busy = 1'b1;
        repeat (BUSY_LEN) @(posedge clk);
        #1 u_if.tx_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int s_wl, s_kl, s_fe, s_lpb;

  task automatic snap();
    s_wl = n_wl; s_kl = n_kl; s_fe = n_fe; s_lpb = n_lpb;
  endtask

  task automatic deltas(input string name, input int wl, input int kl, input int fe, input int lpb);
    chk({name, "_word_load_cnt"}, 64'(n_wl - s_wl), 64'(wl));
    chk({name, "_key_load_cnt"}, 64'(n_kl - s_kl), 64'(kl));
    chk({name, "_frame_err_cnt"}, 64'(n_fe - s_fe), 64'(fe));
    chk({name, "_load_port_b_cnt"}, 64'(n_lpb - s_lpb), 64'(lpb));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 u_if.rx_valid = 1'b1; u_if.rx_byte = b;
    @(posedge clk); #1 u_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 400) begin
      @(negedge clk); #1;
      n++;
      if (!busy && !u_if.tx_busy && mode == M_IDLE && evt_kind == 0) q++;
      else q = 0;
    end
    if (q < 3) begin
      total++; bad++;
      $display("FAIL %s_quiet_timeout: got still busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic chk_log(input string name, input logic [63:0] exp);
    chk({name, "_count"}, 64'(tx_log.size()), 64'd8);
    if (tx_log.size() == 8)
      for (int i = 0; i < 8; i++) chk({name, "_byte"}, tx_log[i], exp[63-8*i -: 8]);
  endtask

  initial begin
    logic [63:0] errs [3];
    int n;
    errs[0] = 64'h02FF010203040005;
    errs[1] = 64'h0211010203040003;
    errs[2] = 64'h02FF010203040103;
    u_if.rx_valid = 1'b0;
    u_if.rx_byte  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_word_out", word_out, 32'h0);
    chk("reset_key_out", key_out, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_start", u_if.tx_start, 1'b0);

    // Data write
    snap();
    send_frame(64'h02FF040816320003);
    wait_quiet("write");
    chk("write_word_out", word_out, 32'h32160804);
    deltas("write", 1, 0, 0, 1);

    // Data readback
    tx_log.delete(); snap();
    send_frame(64'h027F000000000003);
    wait_quiet("read_word");
    chk_log("read_word", 64'h027F040816320003);
    deltas("read_word", 0, 0, 0, 0);

    // Key write and readback
    snap();
    send_frame(64'h02FE0A0B0C0D0003);
    wait_quiet("key");
    chk("key_out", key_out, 32'h0D0C0B0A);
    chk("key_word_unchanged", word_out, 32'h32160804);
    deltas("key", 0, 1, 0, 1);
    tx_log.delete();
    send_frame(64'h027E000000000003);
    wait_quiet("read_key");
    chk_log("read_key", 64'h027E0A0B0C0D0003);

    // Rejected frames
    for (int i = 0; i < 3; i++) begin
      snap();
      send_frame(errs[i]);
      wait_quiet("err");
      deltas("err", 0, 0, 1, 0);
      chk("err_word_kept", word_out, 32'h32160804);
      chk("err_key_kept", key_out, 32'h0D0C0B0A);
    end
    snap();
    send_frame(64'h02FF112233440003);
    wait_quiet("after_err");
    chk("after_err_word", word_out, 32'h44332211);
    deltas("after_err", 1, 0, 0, 1);

    // Inter-byte timeout
    snap();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h01);
    n = 0;
    while (n_fe == s_fe && n < TMO + 10) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    deltas("timeout", 0, 0, 1, 0);
    chk("timeout_busy", busy, 1'b0);
    snap();
    send_frame(64'h02FE556677880003);
    wait_quiet("after_tmo");
    chk("after_tmo_key", key_out, 32'h88776655);
    deltas("after_tmo", 0, 1, 0, 1);

    // Reset in the middle of a reply; bytes sent during the reply are dropped
    tx_log.delete(); snap();
    send_frame(64'h027F000000000003);
    n = 0;
    while (tx_log.size() < 1 && n < 50) begin @(negedge clk); #1; n++; end
    send_byte(8'h02); send_byte(8'hFE); send_byte(8'h01);
    n = 0;
    while (tx_log.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
    chk("abort_starts_before_rst", 64'(tx_log.size()), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    chk("abort_tx_count", 64'(tx_log.size()), 64'd3);
    chk("abort_word_out", word_out, 32'h0);
    chk("abort_key_out", key_out, 32'h0);
    chk("abort_busy", busy, 1'b0);
    deltas("abort", 0, 0, 0, 0);

    // Operation resumes after the reset
    snap();
    send_frame(64'h02FFA1B2C3D40003);
    wait_quiet("resume");
    chk("resume_word", word_out, 32'hD4C3B2A1);
    deltas("resume", 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish by 200000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "time limit");
  end

endmodule
